// File: rtl/uart_pkg.sv
// Shared constants for the UART receive path: default sizes and status byte layout.
package uart_pkg;

   localparam int DEF_DATA_BITS  = 8;
   localparam int DEF_FIFO_DEPTH = 16;
   localparam int DEF_FIFO_AW    = 4;
   localparam int DEF_DIV_W      = 8;

   // Bit positions inside the status byte returned by UARTstat.
   localparam int STAT_NEMPTY  = 0;
   localparam int STAT_FULL    = 1;
   localparam int STAT_OVR     = 2;
   localparam int STAT_CNT_LSB = 3;
   localparam int STAT_CNT_W   = 5;

endpackage

// File: rtl/uart_rx_fifo.sv
// Receive FIFO: storage, wrapping pointers, occupancy count and full/empty flags.
module uart_rx_fifo
   import uart_pkg::*;
#(
   parameter int DATA_BITS  = DEF_DATA_BITS,
   parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
   parameter int FIFO_AW    = DEF_FIFO_AW
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 push,
   input  logic [DATA_BITS-1:0] push_data,
   input  logic                 pop,
   output logic [DATA_BITS-1:0] pop_data,
   output logic                 full,
   output logic                 empty,
   output logic [FIFO_AW:0]     count
);

   logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
   logic [FIFO_AW-1:0]   wrPtr;
   logic [FIFO_AW-1:0]   rdPtr;
   logic                 doPush;
   logic                 doPop;

   assign empty = (count == '0);
   assign full  = (count == (FIFO_AW+1)'(FIFO_DEPTH));

   // A pop from a full FIFO frees the slot the simultaneous push lands in.
   assign doPop  = pop & ~empty;
   assign doPush = push & (~full | doPop);

   assign pop_data = mem[rdPtr];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wrPtr <= '0;
         rdPtr <= '0;
         count <= '0;
      end else begin
         if (doPush) begin
            wrPtr <= wrPtr + 1'b1;
         end
         if (doPop) begin
            rdPtr <= rdPtr + 1'b1;
         end
         case ({doPush, doPop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (doPush) begin
         mem[wrPtr] <= push_data;
      end
   end

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: oversampling tick divider, receive FIFO capture,
// one-cycle-latency read port and status byte for UARTrd / UARTstat.
module uart_rx_ctrl
   import uart_pkg::*;
#(
   parameter int DATA_BITS  = DEF_DATA_BITS,
   parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
   parameter int FIFO_AW    = DEF_FIFO_AW,
   parameter int DIV_W      = DEF_DIV_W
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 baud_en,
   input  logic [DIV_W-1:0]     baud_div,
   output logic                 s_tick,
   input  logic                 rx_done_tick,
   input  logic [DATA_BITS-1:0] rx_data,
   input  logic                 rd_req,
   output logic [DATA_BITS-1:0] rd_data,
   output logic                 rd_valid,
   input  logic                 clr_ovr,
   output logic [7:0]           status
);

   logic [DIV_W-1:0]     divCnt;
   logic [DATA_BITS-1:0] popData;
   logic                 fifoFull;
   logic                 fifoEmpty;
   logic [FIFO_AW:0]     fifoCount;
   logic                 overrun;
   logic                 popAccept;
   logic                 ovrSet;

   // Read handshake: rd_req is a one-cycle request with no ready back-pressure;
   // it is accepted only when the FIFO holds data, and each accepted request
   // yields exactly one rd_valid pulse on the following cycle with rd_data.
   assign popAccept = rd_req & ~fifoEmpty;
   assign ovrSet    = rx_done_tick & fifoFull & ~rd_req;

   // The >= compare makes a shrinking divisor take effect on the next edge.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         divCnt <= '0;
         s_tick <= 1'b0;
      end else if (!baud_en) begin
         divCnt <= '0;
         s_tick <= 1'b0;
      end else if (divCnt >= baud_div) begin
         divCnt <= '0;
         s_tick <= 1'b1;
      end else begin
         divCnt <= divCnt + 1'b1;
         s_tick <= 1'b0;
      end
   end

   uart_rx_fifo #(
      .DATA_BITS  (DATA_BITS),
      .FIFO_DEPTH (FIFO_DEPTH),
      .FIFO_AW    (FIFO_AW)
   ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (rx_done_tick),
      .push_data (rx_data),
      .pop       (rd_req),
      .pop_data  (popData),
      .full      (fifoFull),
      .empty     (fifoEmpty),
      .count     (fifoCount)
   );

   // Set has priority so an overrun coinciding with a clear is not lost.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         overrun <= 1'b0;
      end else if (ovrSet) begin
         overrun <= 1'b1;
      end else if (clr_ovr) begin
         overrun <= 1'b0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_data  <= '0;
         rd_valid <= 1'b0;
      end else begin
         rd_valid <= popAccept;
         if (popAccept) begin
            rd_data <= popData;
         end
      end
   end

   always_comb begin
      status = '0;
      status[STAT_NEMPTY] = ~fifoEmpty;
      status[STAT_FULL]   = fifoFull;
      status[STAT_OVR]    = overrun;
      status[STAT_CNT_LSB +: STAT_CNT_W] = STAT_CNT_W'(fifoCount);
   end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl: tick divider, FIFO fill/drain, overrun and reset.
module tb_uart_rx_ctrl;

   logic       clk = 1'b0;
   logic       reset;
   logic       baud_en;
   logic [7:0] baud_div;
   logic       s_tick;
   logic       rx_done_tick;
   logic [7:0] rx_data;
   logic       rd_req;
   logic [7:0] rd_data;
   logic       rd_valid;
   logic       clr_ovr;
   logic [7:0] status;

   int         total = 0;
   int         bad = 0;
   logic [7:0] exp_q[$];

   uart_rx_ctrl dut (
      .clk          (clk),
      .reset        (reset),
      .baud_en      (baud_en),
      .baud_div     (baud_div),
      .s_tick       (s_tick),
      .rx_done_tick (rx_done_tick),
      .rx_data      (rx_data),
      .rd_req       (rd_req),
      .rd_data      (rd_data),
      .rd_valid     (rd_valid),
      .clr_ovr      (clr_ovr),
      .status       (status)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected test completion");
      $fatal(1);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // One clock of stimulus; inputs return to idle 1ns after the edge.
   task automatic step(input logic push, input logic [7:0] data, input logic rd, input logic clr);
      rx_done_tick = push;
      rx_data      = data;
      rd_req       = rd;
      clr_ovr      = clr;
      @(posedge clk);
      #1;
      rx_done_tick = 1'b0;
      rd_req       = 1'b0;
      clr_ovr      = 1'b0;
   endtask

   task automatic tick_cycle(input logic exp);
      @(posedge clk);
      #1;
      check("s_tick", 32'(s_tick), 32'(exp));
   endtask

   // Scoreboard monitor: every rd_valid pulse must match the oldest expected byte.
   always @(negedge clk) begin : monitor
      logic [7:0] e;
      if (rd_valid) begin
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_rd_valid: got rd_data=0x%0h expected no pop", rd_data);
         end else begin
            e = exp_q.pop_front();
            check("rd_data", 32'(rd_data), 32'(e));
         end
      end
   end

   initial begin
      reset        = 1'b1;
      baud_en      = 1'b0;
      baud_div     = 8'd0;
      rx_done_tick = 1'b0;
      rx_data      = 8'h00;
      rd_req       = 1'b0;
      clr_ovr      = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;

      check("reset_status", 32'(status), 32'h00);
      check("reset_rd_valid", 32'(rd_valid), 32'h0);
      check("reset_rd_data", 32'(rd_data), 32'h00);
      check("reset_s_tick", 32'(s_tick), 32'h0);

      // Divider: period 4, then disable, then re-enable.
      baud_div = 8'd3;
      baud_en  = 1'b1;
      for (int i = 1; i <= 12; i++) tick_cycle((i % 4) == 0);
      baud_en = 1'b0;
      tick_cycle(1'b0);
      tick_cycle(1'b0);
      baud_en = 1'b1;
      for (int i = 1; i <= 4; i++) tick_cycle(i == 4);
      // Divisor 0 ticks every cycle.
      baud_div = 8'd0;
      for (int i = 0; i < 3; i++) tick_cycle(1'b1);
      // Shrinking the divisor below the running count ticks on the next edge.
      baud_div = 8'd7;
      for (int i = 1; i <= 5; i++) tick_cycle(1'b0);
      baud_div = 8'd2;
      tick_cycle(1'b1);
      baud_en = 1'b0;
      tick_cycle(1'b0);

      // Single byte.
      step(1'b1, 8'hA5, 1'b0, 1'b0);
      check("single_status", 32'(status), 32'h09);
      exp_q.push_back(8'hA5);
      step(1'b0, 8'h00, 1'b1, 1'b0);
      check("single_pop_status", 32'(status), 32'h00);

      // Fill to full, then overrun.
      for (int i = 0; i < 16; i++) step(1'b1, 8'(i), 1'b0, 1'b0);
      check("full_status", 32'(status), 32'h83);
      step(1'b1, 8'hFF, 1'b0, 1'b0);
      check("overrun_status", 32'(status), 32'h87);
      step(1'b0, 8'h00, 1'b0, 1'b1);
      check("clr_ovr_status", 32'(status), 32'h83);

      // Push and pop together while full: oldest byte out, no overrun.
      exp_q.push_back(8'h00);
      step(1'b1, 8'h55, 1'b1, 1'b0);
      check("full_push_pop_status", 32'(status), 32'h83);

      // Overrun and clear in the same cycle: set wins, byte discarded.
      step(1'b1, 8'h99, 1'b0, 1'b1);
      check("set_wins_status", 32'(status), 32'h87);
      step(1'b0, 8'h00, 1'b0, 1'b1);
      check("clr_again_status", 32'(status), 32'h83);

      // Back-to-back drain across the pointer wrap.
      for (int i = 1; i < 16; i++) exp_q.push_back(8'(i));
      exp_q.push_back(8'h55);
      for (int i = 0; i < 16; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
      check("drained_status", 32'(status), 32'h00);
      step(1'b0, 8'h00, 1'b0, 1'b0);

      // Empty read with a push in the same cycle: no bypass.
      step(1'b1, 8'h3C, 1'b1, 1'b0);
      @(negedge clk);
      check("empty_rd_valid", 32'(rd_valid), 32'h0);
      check("empty_push_status", 32'(status), 32'h09);
      exp_q.push_back(8'h3C);
      step(1'b0, 8'h00, 1'b1, 1'b0);
      check("after_3c_status", 32'(status), 32'h00);

      // Reset in the middle of traffic.
      for (int i = 0; i < 5; i++) step(1'b1, 8'h10 + 8'(i), 1'b0, 1'b0);
      check("five_status", 32'(status), 32'h29);
      #2;
      reset = 1'b1;
      #1;
      check("midreset_status", 32'(status), 32'h00);
      check("midreset_rd_valid", 32'(rd_valid), 32'h0);
      check("midreset_rd_data", 32'(rd_data), 32'h00);
      @(posedge clk);
      #1;
      reset = 1'b0;
      step(1'b0, 8'h00, 1'b1, 1'b0);
      @(negedge clk);
      check("post_reset_rd_valid", 32'(rd_valid), 32'h0);
      check("post_reset_status", 32'(status), 32'h00);

      repeat (3) @(posedge clk);
      #1;
      check("exp_q_drained", 32'(exp_q.size()), 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
